// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit.
//   - opcode encodings for the supported instructions
//   - sequencer state enum and instruction-class enum
//   - IR field bit positions
package cpu_defs_pkg;

    // IR field positions
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned RA_HI  = 26;
    localparam int unsigned RA_LO  = 23;
    localparam int unsigned RB_HI  = 22;
    localparam int unsigned RB_LO  = 19;
    localparam int unsigned RC_HI  = 18;
    localparam int unsigned RC_LO  = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_3R,
        CLS_2R,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } cls_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier.
//   opcode : in  5-bit opcode field of the IR
//   cls    : out instruction class (3R, 2R, nop, halt, illegal)
module op_decode
    import cpu_defs_pkg::*;
(
    input  logic [4:0] opcode,
    output cls_t       cls
);

    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  cls = CLS_3R;
            OP_NEG, OP_NOT:                   cls = CLS_2R;
            OP_NOP:                           cls = CLS_NOP;
            OP_HALT:                          cls = CLS_HALT;
            default:                          cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: fetch (T0-T2) and execute (T3-T5) for
// register-register ALU instructions, nop and halt.
//   clock, clear    : clock and asynchronous active-high reset
//   ir              : datapath IR contents (opcode in ir[31:27])
//   mem_done        : memory read data valid, ends the T1 wait
//   PCout..Yin      : datapath transfer strobes
//   Gra/Grb/Grc/Rin/Rout : register-file select-and-encode controls
//   alu_op          : opcode during the ALU cycle, else 0
//   run             : high outside IDLE and HALT
//   illegal         : in HALT, set when an unsupported opcode caused it
module control_unit
    import cpu_defs_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_done,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    state_t     state_q;
    logic       illegal_q;
    cls_t       cls;
    logic [4:0] opcode;

    assign opcode = ir[OPC_HI:OPC_LO];

    // Register fields are consumed by the datapath's select-and-encode logic,
    // not by the sequencer.
    logic unused_fields;
    assign unused_fields = ^{ir[RA_HI:RA_LO], ir[RB_HI:RB_LO], ir[RC_HI:RC_LO], ir[RC_LO-1:0]};

    op_decode u_op_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_T0;
                S_T0:   state_q <= S_T1;
                S_T1:   if (mem_done) state_q <= S_T2;
                S_T2: begin
                    case (cls)
                        CLS_3R, CLS_2R: state_q <= S_T3;
                        CLS_NOP:        state_q <= S_T0;
                        CLS_HALT: begin
                            state_q   <= S_HALT;
                            illegal_q <= 1'b0;
                        end
                        default: begin
                            state_q   <= S_HALT;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_T3:   state_q <= S_T4;
                S_T4:   state_q <= (cls == CLS_2R) ? S_T0 : S_T5;
                S_T5:   state_q <= S_T0;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode; 2R instructions use T3 as their ALU cycle, 3R use T4.
    always_comb begin
        PCout   = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        alu_op  = '0;
        run     = (state_q != S_IDLE) && (state_q != S_HALT);
        illegal = (state_q == S_HALT) && illegal_q;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                MARin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Grb  = 1'b1;
                Rout = 1'b1;
                if (cls == CLS_2R) begin
                    Zin    = 1'b1;
                    alu_op = opcode;
                end else begin
                    Yin = 1'b1;
                end
            end
            S_T4: begin
                if (cls == CLS_2R) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = opcode;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
